// File: rtl/config_pkg.sv
// config_pkg: shared definitions for the configuration loader slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package config_pkg;

  // Width of one configuration word pushed by the host.
  localparam int WORD_W = 32;

  // Default number of configuration bits in the downstream serial chain.
  localparam int CHAIN_LEN_DEF = 16;

  // Loader session states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } cfg_state_t;

endpackage

// File: rtl/cfg_shifter.sv
// cfg_shifter: parallel-in/serial-out of config words plus serial-in/parallel-out readback capture.
// Latency: bit 0 appears on prog_in in the cycle after load; rb_data updates on the commit edge.
// Backpressure: none; shifts whenever shift is high, the controlling FSM does all flow control.
//
// Ports:
//   prog_clk, rst       clock and asynchronous active-high reset
//   load, load_word     capture a new word and restart the bit index
//   shift               chain shift enable for this cycle (drives prog_in gating)
//   commit              this is the final bit of the word; publish the captured readback
//   prog_out            serial bit from the chain tail, sampled while shifting
//   prog_in             serial bit to the chain head, forced to 0 when not shifting
//   rb_data             last published readback word
module cfg_shifter
  import config_pkg::*;
#(
  parameter int DATA_W = WORD_W
) (
  input  logic              prog_clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_word,
  input  logic              shift,
  input  logic              commit,
  input  logic              prog_out,
  output logic              prog_in,
  output logic [DATA_W-1:0] rb_data
);

  localparam int IDX_W = $clog2(DATA_W);

  logic [DATA_W-1:0] piso_q;
  logic [DATA_W-1:0] sipo_q;
  logic [DATA_W-1:0] sipo_d;
  logic [IDX_W-1:0]  idx_q;

  // Gate with shift so the chain head sees 0 whenever it is not being clocked.
  assign prog_in = shift & piso_q[0];

  // Readback word including the bit sampled this cycle; used both for the
  // running capture and for the published word on the final bit.
  always_comb begin
    sipo_d        = sipo_q;
    sipo_d[idx_q] = prog_out;
  end

  always_ff @(posedge prog_clk or posedge rst) begin
    if (rst) begin
      piso_q  <= '0;
      sipo_q  <= '0;
      idx_q   <= '0;
      rb_data <= '0;
    end else if (load) begin
      // Clearing the capture here keeps unused upper bits of a short word at 0.
      piso_q <= load_word;
      sipo_q <= '0;
      idx_q  <= '0;
    end else if (shift) begin
      piso_q <= piso_q >> 1;
      sipo_q <= sipo_d;
      idx_q  <= idx_q + 1'b1;
      if (commit) begin
        rb_data <= sipo_d;
      end
    end
  end

endmodule

// File: rtl/config_loader.sv
// config_loader: loads CHAIN_LEN bits into a serial config chain from 32-bit words, LSB first, and returns the old chain contents.
// Latency: prog_en rises the cycle after a word is accepted; rb_valid one cycle after each word's last bit; done follows the final word.
// Backpressure: word_ready only in FETCH; no buffering, so a late word_valid just idles the chain with prog_en low.
//
// Ports:
//   prog_clk, rst        clock and asynchronous active-high reset
//   start, abort         begin a session (IDLE only) / kill the session in progress
//   word_data/valid/ready  configuration word handshake
//   prog_in, prog_en     serial data and shift enable to the chain head
//   prog_out             serial readback from the chain tail
//   busy, done           session in progress / one-cycle completion pulse
//   rb_data, rb_valid    captured readback word and its one-cycle strobe
module config_loader #(
  parameter int CHAIN_LEN = config_pkg::CHAIN_LEN_DEF,
  parameter int WORD_W    = config_pkg::WORD_W
) (
  input  logic              prog_clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              prog_in,
  output logic              prog_en,
  input  logic              prog_out,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid
);

  import config_pkg::*;

  localparam int REM_W = $clog2(CHAIN_LEN + 1);
  localparam int CNT_W = $clog2(WORD_W + 1);

  cfg_state_t       state_q, state_d;
  logic [REM_W-1:0] rem_q, rem_d;      // chain bits not yet handed to a word
  logic [CNT_W-1:0] bits_q, bits_d;    // bits left in the word being shifted
  logic [CNT_W-1:0] word_n;            // bits this word will contribute
  logic             prog_en_q, prog_en_d;
  logic             rb_valid_q, rb_valid_d;
  logic             load, commit;
  logic             kill;

  // abort only matters once a session exists; in IDLE it is a no-op.
  assign kill = abort & (state_q != IDLE);

  // word_n never exceeds rem_q, so narrowing it back to REM_W loses nothing.
  assign word_n = (32'(rem_q) >= WORD_W) ? CNT_W'(WORD_W) : CNT_W'(rem_q);

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    bits_d     = bits_q;
    prog_en_d  = 1'b0;
    rb_valid_d = 1'b0;
    load       = 1'b0;
    commit     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          rem_d   = REM_W'(CHAIN_LEN);
        end
      end
      FETCH: begin
        if (word_valid) begin
          load      = 1'b1;
          bits_d    = word_n;
          rem_d     = rem_q - REM_W'(word_n);
          prog_en_d = 1'b1;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        bits_d = bits_q - 1'b1;
        if (bits_q == CNT_W'(1)) begin
          // Last bit of the word: drop prog_en for at least the FETCH/DONE cycle.
          commit     = 1'b1;
          rb_valid_d = 1'b1;
          state_d    = (rem_q != '0) ? FETCH : DONE;
        end else begin
          prog_en_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // abort wins over every other event in the same cycle.
    if (kill) begin
      state_d    = IDLE;
      rem_d      = '0;
      bits_d     = '0;
      prog_en_d  = 1'b0;
      rb_valid_d = 1'b0;
      load       = 1'b0;
      commit     = 1'b0;
    end
  end

  always_ff @(posedge prog_clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      bits_q     <= '0;
      prog_en_q  <= 1'b0;
      rb_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      bits_q     <= bits_d;
      prog_en_q  <= prog_en_d;
      rb_valid_q <= rb_valid_d;
    end
  end

  // Strobes are masked by abort so a killed session never reports completion.
  assign word_ready = (state_q == FETCH) & ~abort;
  assign done       = (state_q == DONE) & ~abort;
  assign rb_valid   = rb_valid_q & ~abort;
  assign busy       = (state_q != IDLE);
  assign prog_en    = prog_en_q;

  cfg_shifter #(
    .DATA_W (WORD_W)
  ) u_shifter (
    .prog_clk  (prog_clk),
    .rst       (rst),
    .load      (load),
    .load_word (word_data),
    .shift     (prog_en_q),
    .commit    (commit),
    .prog_out  (prog_out),
    .prog_in   (prog_in),
    .rb_data   (rb_data)
  );

endmodule

// File: tb/tb_config_loader.sv
// tb_config_loader: two loaders (16-bit and 40-bit chains) driving behavioural serial chains,
// checked by a scoreboard fed from the stimulus side and drained by a negedge monitor.
module tb_config_loader;

  localparam int L0 = 16;
  localparam int L1 = 40;

  logic        prog_clk = 1'b0;
  logic        rst;
  logic        start_s      [2];
  logic        abort_s      [2];
  logic        word_valid_s [2];
  logic [31:0] word_data_s  [2];
  logic        word_ready_s [2];
  logic        prog_in_s    [2];
  logic        prog_en_s    [2];
  logic        prog_out_s   [2];
  logic        busy_s       [2];
  logic        done_s       [2];
  logic        rb_valid_s   [2];
  logic [31:0] rb_data_s    [2];

  logic [63:0] chain [2];   // chain contents, bit 0 is the tail
  logic [63:0] seed  [2];
  logic        seed_load;
  logic [63:0] img   [2];   // expected chain contents

  int checks = 0;
  int errors = 0;
  int done_seen [2];
  int done_exp  [2];
  int rb_seen   [2];
  int rb_exp    [2];
  int run_cnt   [2];
  int sess_cnt  [2];

  // Tags carry the instance so activity on the wrong loader is caught too.
  int          exp_bit_q  [$];
  int          exp_run_q  [$];
  int          exp_done_q [$];
  logic [32:0] exp_rb_q   [$];

  always #5 prog_clk = ~prog_clk;

  config_loader #(.CHAIN_LEN(L0), .WORD_W(32)) u_dut16 (
    .prog_clk(prog_clk), .rst(rst), .start(start_s[0]), .abort(abort_s[0]),
    .word_data(word_data_s[0]), .word_valid(word_valid_s[0]), .word_ready(word_ready_s[0]),
    .prog_in(prog_in_s[0]), .prog_en(prog_en_s[0]), .prog_out(prog_out_s[0]),
    .busy(busy_s[0]), .done(done_s[0]), .rb_data(rb_data_s[0]), .rb_valid(rb_valid_s[0])
  );

  config_loader #(.CHAIN_LEN(L1), .WORD_W(32)) u_dut40 (
    .prog_clk(prog_clk), .rst(rst), .start(start_s[1]), .abort(abort_s[1]),
    .word_data(word_data_s[1]), .word_valid(word_valid_s[1]), .word_ready(word_ready_s[1]),
    .prog_in(prog_in_s[1]), .prog_en(prog_en_s[1]), .prog_out(prog_out_s[1]),
    .busy(busy_s[1]), .done(done_s[1]), .rb_data(rb_data_s[1]), .rb_valid(rb_valid_s[1])
  );

  function automatic int clen(input int i);
    return (i == 0) ? L0 : L1;
  endfunction

  function automatic logic [63:0] mask(input int n);
    if (n >= 64) return '1;
    return (64'd1 << n) - 64'd1;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Serial chain: head takes prog_in, tail presents its pre-shift bit on prog_out.
  assign prog_out_s[0] = chain[0][0];
  assign prog_out_s[1] = chain[1][0];

  always @(posedge prog_clk) begin
    for (int i = 0; i < 2; i++) begin
      if (seed_load) chain[i] <= seed[i];
      else if (prog_en_s[i])
        chain[i] <= (chain[i] >> 1) | (64'(prog_in_s[i]) << (clen(i) - 1));
    end
  end

  // Monitor: drains the scoreboard whenever a loader presents something.
  always @(negedge prog_clk) begin
    for (int i = 0; i < 2; i++) begin
      if (prog_en_s[i] === 1'b1) begin
        run_cnt[i]++;
        sess_cnt[i]++;
        if (exp_bit_q.size() == 0) chk("unexpected_bit", 64'(i * 2 + int'(prog_in_s[i])), 64'hDEAD);
        else chk("prog_in_bit", 64'(i * 2 + int'(prog_in_s[i])), 64'(exp_bit_q.pop_front()));
      end else begin
        chk("prog_in_idle", 64'(prog_in_s[i]), 64'd0);
        if (run_cnt[i] > 0) begin
          if (exp_run_q.size() == 0) chk("unexpected_run", 64'(i * 1000 + run_cnt[i]), 64'hDEAD);
          else chk("prog_en_run_len", 64'(i * 1000 + run_cnt[i]), 64'(exp_run_q.pop_front()));
          run_cnt[i] = 0;
        end
      end
      if (rb_valid_s[i] === 1'b1) begin
        rb_seen[i]++;
        if (exp_rb_q.size() == 0) chk("unexpected_rb_valid", {31'd0, i[0], rb_data_s[i]}, 64'hDEAD);
        else chk("rb_data", {31'd0, i[0], rb_data_s[i]}, {31'd0, exp_rb_q.pop_front()});
      end
      if (done_s[i] === 1'b1) begin
        done_seen[i]++;
        if (exp_done_q.size() == 0) chk("unexpected_done", 64'(i * 10000 + sess_cnt[i]), 64'hDEAD);
        else chk("done_total_bits", 64'(i * 10000 + sess_cnt[i]), 64'(exp_done_q.pop_front()));
      end
      if (busy_s[i] !== 1'b1) sess_cnt[i] = 0;
    end
  end

  // One load session. cut>0 interrupts after that many chain bits (abort, or rst if use_rst).
  task automatic session(input int i, input logic [31:0] w0, input logic [31:0] w1,
                         input int dly, input int cut, input bit use_rst);
    int L, s0, n, sh, t;
    bit intr, stopped;
    logic [63:0] pre, loaded;
    logic [31:0] w;
    L = clen(i); pre = img[i]; loaded = '0; s0 = 0; stopped = 0;
    start_s[i] = 1'b1;
    @(posedge prog_clk); #1;
    start_s[i] = 1'b0;
    chk("busy_after_start", 64'(busy_s[i]), 64'd1);
    while (s0 < L && !stopped) begin
      w    = (s0 == 0) ? w0 : w1;
      n    = (L - s0 < 32) ? (L - s0) : 32;
      intr = (cut > 0 && cut <= s0 + n);
      sh   = intr ? (cut - s0) : n;
      t = 0;
      while (word_ready_s[i] !== 1'b1 && t < 200) begin @(posedge prog_clk); #1; t++; end
      chk("word_ready_wait", 64'(word_ready_s[i]), 64'd1);
      for (int d = 0; d < dly; d++) begin
        chk("fetch_wait_ready_no_shift", {62'd0, word_ready_s[i], prog_en_s[i]}, 64'd2);
        @(posedge prog_clk); #1;
      end
      for (int b = 0; b < sh; b++) exp_bit_q.push_back(i * 2 + int'(w[b]));
      exp_run_q.push_back(i * 1000 + sh);
      if (!intr) begin
        exp_rb_q.push_back({i[0], 32'((pre >> s0) & mask(n))});
        rb_exp[i]++;
      end
      loaded |= (64'(w) & mask(n)) << s0;
      if (!intr && s0 + n == L) begin
        exp_done_q.push_back(i * 10000 + L);
        done_exp[i]++;
      end
      word_data_s[i] = w; word_valid_s[i] = 1'b1;
      @(posedge prog_clk); #1;
      word_valid_s[i] = 1'b0; word_data_s[i] = $urandom;
      chk("prog_en_after_accept", 64'(prog_en_s[i]), 64'd1);
      if (intr) begin
        for (int b = 1; b < sh; b++) begin @(posedge prog_clk); #1; end
        if (use_rst) begin
          @(posedge prog_clk); #2;
          rst = 1'b1; #1;
          chk("rst_outputs", {25'd0, prog_en_s[i], prog_in_s[i], busy_s[i], done_s[i],
              word_ready_s[i], rb_valid_s[i], rb_data_s[i]}, 64'd0);
        end else begin
          abort_s[i] = 1'b1;
          @(posedge prog_clk); #1;
          abort_s[i] = 1'b0;
          chk("abort_outputs", {61'd0, prog_en_s[i], busy_s[i], word_ready_s[i]}, 64'd0);
        end
        stopped = 1;
        s0 += sh;
      end else begin
        s0 += n;
      end
    end
    if (!stopped) begin
      t = 0;
      while (busy_s[i] === 1'b1 && t < 200) begin @(posedge prog_clk); #1; t++; end
      chk("session_end_idle", 64'(busy_s[i]), 64'd0);
    end
    img[i] = (pre >> s0) | ((loaded & mask(s0)) << (L - s0));
    chk("chain_image", chain[i] & mask(L), img[i]);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int i, cut;
    rst = 1'b1;
    seed_load = 1'b1;
    for (int k = 0; k < 2; k++) begin
      start_s[k] = 1'b0; abort_s[k] = 1'b0; word_valid_s[k] = 1'b0; word_data_s[k] = '0;
      done_seen[k] = 0; done_exp[k] = 0; rb_seen[k] = 0; rb_exp[k] = 0;
      run_cnt[k] = 0; sess_cnt[k] = 0;
      seed[k] = {$urandom, $urandom} & mask(clen(k));
      img[k]  = seed[k];
    end
    repeat (3) @(posedge prog_clk);
    #1;
    seed_load = 1'b0;
    for (int k = 0; k < 2; k++)
      chk("reset_state", {25'd0, busy_s[k], done_s[k], word_ready_s[k], prog_en_s[k],
          prog_in_s[k], rb_valid_s[k], rb_data_s[k]}, 64'd0);
    rst = 1'b0;

    // 16-bit chain: known word, readback of it, stalled word, abort, mid-shift reset.
    session(0, 32'h0000A5C3, 32'h0, 0, 0, 0);
    session(0, 32'h00001234, 32'h0, 0, 0, 0);
    session(0, $urandom, 32'h0, 5, 0, 0);
    session(0, $urandom, 32'h0, 0, 10, 0);
    session(0, $urandom, 32'h0, 2, 0, 0);
    session(0, $urandom, 32'h0, 0, 6, 1);
    repeat (2) @(posedge prog_clk);
    #1;
    start_s[0] = 1'b1;
    rst = 1'b0;
    @(posedge prog_clk); #1;
    start_s[0] = 1'b0;
    chk("start_after_rst", {62'd0, busy_s[0], word_ready_s[0]}, 64'd3);
    abort_s[0] = 1'b1;
    @(posedge prog_clk); #1;
    abort_s[0] = 1'b0;
    chk("abort_in_fetch", 64'(busy_s[0]), 64'd0);
    session(0, $urandom, 32'h0, 1, 0, 0);

    // 40-bit chain: full word then partial word.
    session(1, 32'hFFFFFFFF, 32'h000000AB, 0, 0, 0);
    session(1, $urandom, $urandom, 1, 0, 0);

    for (int r = 0; r < 14; r++) begin
      i   = r % 2;
      cut = ($urandom_range(3) == 0) ? int'($urandom_range(clen(i), 1)) : 0;
      session(i, $urandom, $urandom, int'($urandom_range(3)), cut, 0);
      repeat (int'($urandom_range(2))) @(posedge prog_clk);
      #1;
    end

    repeat (3) @(posedge prog_clk);
    #1;
    chk("bit_queue_drained", 64'(exp_bit_q.size()), 64'd0);
    chk("run_queue_drained", 64'(exp_run_q.size()), 64'd0);
    chk("rb_queue_drained", 64'(exp_rb_q.size()), 64'd0);
    chk("done_queue_drained", 64'(exp_done_q.size()), 64'd0);
    for (int k = 0; k < 2; k++) begin
      chk("done_pulse_count", 64'(done_seen[k]), 64'(done_exp[k]));
      chk("rb_valid_pulse_count", 64'(rb_seen[k]), 64'(rb_exp[k]));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
